// File: rtl/bcd_defs.sv
// Shared definitions for the serial packed-BCD adder: FSM encodings and BCD constants.
package bcd_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder. Invalid digits take the same +6 rule as valid ones; no saturation.
module bcd_digit_add
  import bcd_defs::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] bin;
  logic [4:0] adj;

  always_comb begin
    bin = 5'(a) + 5'(b) + 5'(ci);
    adj = bin + 5'(BCD_CORR);
    s   = bin[3:0];
    co  = 1'b0;
    if (bin > 5'(BCD_MAX)) begin
      s  = adj[3:0];
      co = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Multi-digit packed-BCD adder: one digit per clock, LSD first, through a shared digit adder.
module bcd_serial_add_ctrl
  import bcd_defs::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                ci,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                co,
  output logic                err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = $clog2(DIGITS);

  state_t          state;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic            carry;
  logic [IW-1:0]   idx;
  logic [3:0]      dsum;
  logic            dco;

  // Operands shift right each RUN cycle, so the active digit is always at [3:0].
  bcd_digit_add u_digit (
    .a  (opa[3:0]),
    .b  (opb[3:0]),
    .ci (carry),
    .s  (dsum),
    .co (dco)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      co    <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= ci;
            idx   <= '0;
            sum   <= '0;
            err   <= 1'b0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum[{idx, 2'b00} +: 4] <= dsum;
          carry <= dco;
          err   <= err | (opa[3:0] > BCD_MAX) | (opb[3:0] > BCD_MAX);
          opa   <= opa >> 4;
          opb   <= opb >> 4;
          idx   <= idx + IW'(1);
          if (idx == IW'(DIGITS - 1)) begin
            co    <= dco;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl (DIGITS=4) with hand-computed expected results.
module tb_bcd_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ci;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        co;
  logic        err;

  int checks = 0;
  int errors = 0;

  int          bcnt;
  int          dat;
  int          dcnt;
  logic        err_acc;
  logic [15:0] sum_acc;
  int          seen_done;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operation, scramble inputs afterwards, and observe 10 cycles.
  // With inject set, start is re-asserted with other operands through RUN and DONE.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic civ,
                       input bit inject, output int bc, output int da, output int dc,
                       output logic e1, output logic [15:0] s1);
    a = av; b = bv; ci = civ; start = 1'b1;
    tick();
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1;
    e1 = err; s1 = sum;
    bc = 0; da = 0; dc = 0;
    for (int i = 1; i <= 10; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (da == 0) da = i;
      end
      if (inject && i <= 5) begin
        start = 1'b1; a = 16'h1111; b = 16'h1111;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
  endtask

  task automatic check_op(input string tag, input logic [15:0] es, input logic eco, input logic eerr);
    check({tag, " busy_cycles"}, 32'(bcnt), 32'd4);
    check({tag, " done_at"}, 32'(dat), 32'd5);
    check({tag, " done_count"}, 32'(dcnt), 32'd1);
    check({tag, " sum"}, 32'(sum), 32'(es));
    check({tag, " co"}, 32'(co), 32'(eco));
    check({tag, " err"}, 32'(err), 32'(eerr));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
    tick();
    tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset sum", 32'(sum), 32'd0);
    check("reset co", 32'(co), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, bcnt, dat, dcnt, err_acc, sum_acc);
    check_op("1234+4321", 16'h5555, 1'b0, 1'b0);

    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, bcnt, dat, dcnt, err_acc, sum_acc);
    check_op("9999+0001", 16'h0000, 1'b1, 1'b0);

    do_op(16'h9999, 16'h9999, 1'b1, 1'b0, bcnt, dat, dcnt, err_acc, sum_acc);
    check_op("9999+9999+1", 16'h9999, 1'b1, 1'b0);

    do_op(16'h0005, 16'h0005, 1'b0, 1'b1, bcnt, dat, dcnt, err_acc, sum_acc);
    check_op("0005+0005 ignored start", 16'h0010, 1'b0, 1'b0);

    // Set co=1 first so the reset check below is meaningful.
    do_op(16'h9999, 16'h0001, 1'b0, 1'b0, bcnt, dat, dcnt, err_acc, sum_acc);
    check("pre-abort co", 32'(co), 32'd1);

    a = 16'h4444; b = 16'h4444; ci = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort sum", 32'(sum), 32'd0);
    check("abort co", 32'(co), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen_done++;
      tick();
    end
    check("abort no done", 32'(seen_done), 32'd0);

    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, bcnt, dat, dcnt, err_acc, sum_acc);
    check_op("0001+0002 after abort", 16'h0003, 1'b0, 1'b0);

    do_op(16'h00A0, 16'h0000, 1'b0, 1'b0, bcnt, dat, dcnt, err_acc, sum_acc);
    check_op("00A0+0000 invalid", 16'h0100, 1'b0, 1'b1);

    do_op(16'h0999, 16'h0001, 1'b0, 1'b0, bcnt, dat, dcnt, err_acc, sum_acc);
    check("err clear at accept", 32'(err_acc), 32'd0);
    check("sum clear at accept", 32'(sum_acc), 32'd0);
    check_op("0999+0001", 16'h1000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
